// File: rtl/axis_frame_length_stats.sv
// axis_frame_length_stats: per-interval frame/pad/truncate statistics with saturating accumulators and snapshot
module axis_frame_length_stats #(
  parameter int COUNT_WIDTH = 32,
  parameter int BYTE_COUNT_WIDTH = 48,
  parameter bit CLEAR_ON_SNAPSHOT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_status_valid,
  output logic                        s_status_ready,
  input  logic                        s_status_frame_pad,
  input  logic                        s_status_frame_truncate,
  input  logic [15:0]                 s_status_frame_length,
  input  logic [15:0]                 s_status_frame_original_length,
  input  logic                        snapshot,
  input  logic                        clear,
  output logic                        stat_valid,
  output logic [COUNT_WIDTH-1:0]      stat_frame_count,
  output logic [COUNT_WIDTH-1:0]      stat_pad_count,
  output logic [COUNT_WIDTH-1:0]      stat_truncate_count,
  output logic [BYTE_COUNT_WIDTH-1:0] stat_byte_count,
  output logic [BYTE_COUNT_WIDTH-1:0] stat_pad_bytes,
  output logic [BYTE_COUNT_WIDTH-1:0] stat_truncate_bytes,
  output logic [15:0]                 stat_min_length,
  output logic [15:0]                 stat_max_length
);
  localparam int CW = COUNT_WIDTH;
  localparam int BW = BYTE_COUNT_WIDTH;
  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] a, input logic en);
    return (en && a != '1) ? a + CW'(1) : a;
  endfunction
  function automatic logic [BW-1:0] add_sat(input logic [BW-1:0] a, input logic [15:0] b);
    logic [BW:0] s;
    s = {1'b0, a} + (BW+1)'(b);
    return s[BW] ? '1 : s[BW-1:0];
  endfunction
  logic          accept, acc_pad, acc_trunc;
  logic [15:0]   len, pad_diff, trunc_diff;
  logic [CW-1:0] frame_cnt, pad_cnt, trunc_cnt, run_frame, run_pad, run_trunc;
  logic [BW-1:0] byte_acc, pad_acc, trunc_acc, run_byte, run_padb, run_truncb;
  logic [15:0]   min_acc, max_acc, run_min, run_max;
  assign accept     = s_status_valid && s_status_ready;
  assign acc_pad    = accept && s_status_frame_pad;
  assign acc_trunc  = accept && s_status_frame_truncate;
  assign len        = s_status_frame_length;
  assign pad_diff   = acc_pad ? len - s_status_frame_original_length : 16'd0;
  assign trunc_diff = acc_trunc ? s_status_frame_original_length - len : 16'd0;
  assign run_frame  = inc_sat(frame_cnt, accept);
  assign run_pad    = inc_sat(pad_cnt, acc_pad);
  assign run_trunc  = inc_sat(trunc_cnt, acc_trunc);
  assign run_byte   = add_sat(byte_acc, accept ? len : 16'd0);
  assign run_padb   = add_sat(pad_acc, pad_diff);
  assign run_truncb = add_sat(trunc_acc, trunc_diff);
  assign run_min    = (accept && len < min_acc) ? len : min_acc;
  assign run_max    = (accept && len > max_acc) ? len : max_acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_status_ready      <= 1'b0;
      stat_valid          <= 1'b0;
      stat_frame_count    <= '0;
      stat_pad_count      <= '0;
      stat_truncate_count <= '0;
      stat_byte_count     <= '0;
      stat_pad_bytes      <= '0;
      stat_truncate_bytes <= '0;
      stat_min_length     <= '0;
      stat_max_length     <= '0;
      frame_cnt           <= '0;
      pad_cnt             <= '0;
      trunc_cnt           <= '0;
      byte_acc            <= '0;
      pad_acc             <= '0;
      trunc_acc           <= '0;
      min_acc             <= '1;
      max_acc             <= '0;
    end else begin
      s_status_ready <= 1'b1;
      stat_valid     <= snapshot;
      if (snapshot) begin
        stat_frame_count    <= run_frame;
        stat_pad_count      <= run_pad;
        stat_truncate_count <= run_trunc;
        stat_byte_count     <= run_byte;
        stat_pad_bytes      <= run_padb;
        stat_truncate_bytes <= run_truncb;
        stat_min_length     <= run_frame == '0 ? '0 : run_min;
        stat_max_length     <= run_frame == '0 ? '0 : run_max;
      end
      // snapshot+clear drops the concurrent record; clear alone starts the new interval with it
      if (snapshot && (clear || CLEAR_ON_SNAPSHOT)) begin
        frame_cnt <= '0;
        pad_cnt   <= '0;
        trunc_cnt <= '0;
        byte_acc  <= '0;
        pad_acc   <= '0;
        trunc_acc <= '0;
        min_acc   <= '1;
        max_acc   <= '0;
      end else if (clear) begin
        frame_cnt <= CW'(accept);
        pad_cnt   <= CW'(acc_pad);
        trunc_cnt <= CW'(acc_trunc);
        byte_acc  <= accept ? BW'(len) : '0;
        pad_acc   <= BW'(pad_diff);
        trunc_acc <= BW'(trunc_diff);
        min_acc   <= accept ? len : '1;
        max_acc   <= accept ? len : '0;
      end else begin
        frame_cnt <= run_frame;
        pad_cnt   <= run_pad;
        trunc_cnt <= run_trunc;
        byte_acc  <= run_byte;
        pad_acc   <= run_padb;
        trunc_acc <= run_truncb;
        min_acc   <= run_min;
        max_acc   <= run_max;
      end
    end
  end
endmodule

// File: tb/tb_axis_frame_length_stats.sv
// tb_axis_frame_length_stats: directed checks on default, no-clear-on-snapshot and 4-bit-counter instances
module tb_axis_frame_length_stats;
  logic clk = 0, rst = 1, valid = 0, pad = 0, trunc = 0, snapshot = 0, clear = 0;
  logic [15:0] len = 0, orig = 0;
  logic a_rdy, a_sv, n_rdy, n_sv, w_rdy, w_sv;
  logic [31:0] a_fc, a_pc, a_tc, n_fc, n_pc, n_tc;
  logic [3:0] w_fc, w_pc, w_tc;
  logic [47:0] a_bc, a_pb, a_tb, n_bc, n_pb, n_tb, w_bc, w_pb, w_tb;
  logic [15:0] a_mn, a_mx, n_mn, n_mx, w_mn, w_mx;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  axis_frame_length_stats dut (
    .clk(clk), .rst(rst), .s_status_valid(valid), .s_status_ready(a_rdy),
    .s_status_frame_pad(pad), .s_status_frame_truncate(trunc),
    .s_status_frame_length(len), .s_status_frame_original_length(orig),
    .snapshot(snapshot), .clear(clear), .stat_valid(a_sv),
    .stat_frame_count(a_fc), .stat_pad_count(a_pc), .stat_truncate_count(a_tc),
    .stat_byte_count(a_bc), .stat_pad_bytes(a_pb), .stat_truncate_bytes(a_tb),
    .stat_min_length(a_mn), .stat_max_length(a_mx));
  axis_frame_length_stats #(.CLEAR_ON_SNAPSHOT(0)) dut_nc (
    .clk(clk), .rst(rst), .s_status_valid(valid), .s_status_ready(n_rdy),
    .s_status_frame_pad(pad), .s_status_frame_truncate(trunc),
    .s_status_frame_length(len), .s_status_frame_original_length(orig),
    .snapshot(snapshot), .clear(clear), .stat_valid(n_sv),
    .stat_frame_count(n_fc), .stat_pad_count(n_pc), .stat_truncate_count(n_tc),
    .stat_byte_count(n_bc), .stat_pad_bytes(n_pb), .stat_truncate_bytes(n_tb),
    .stat_min_length(n_mn), .stat_max_length(n_mx));
  axis_frame_length_stats #(.COUNT_WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst), .s_status_valid(valid), .s_status_ready(w_rdy),
    .s_status_frame_pad(pad), .s_status_frame_truncate(trunc),
    .s_status_frame_length(len), .s_status_frame_original_length(orig),
    .snapshot(snapshot), .clear(clear), .stat_valid(w_sv),
    .stat_frame_count(w_fc), .stat_pad_count(w_pc), .stat_truncate_count(w_tc),
    .stat_byte_count(w_bc), .stat_pad_bytes(w_pb), .stat_truncate_bytes(w_tb),
    .stat_min_length(w_mn), .stat_max_length(w_mx));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic rec(input logic [15:0] l, input logic [15:0] o, input logic p, input logic t);
    valid = 1; len = l; orig = o; pad = p; trunc = t;
    tick();
    valid = 0; pad = 0; trunc = 0;
  endtask
  task automatic snap();
    snapshot = 1;
    tick();
    snapshot = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    chk("reset_ready", a_rdy, 0);
    chk("reset_valid", a_sv, 0);
    chk("reset_frame", a_fc, 0);
    chk("reset_min", a_mn, 0);
    rst = 0;
    tick();
    chk("ready_after_reset", a_rdy, 1);
    snap();
    chk("empty_valid", a_sv, 1);
    chk("empty_frame", a_fc, 0);
    chk("empty_bytes", a_bc, 0);
    chk("empty_min", a_mn, 0);
    chk("empty_max", a_mx, 0);
    tick();
    chk("empty_valid_drop", a_sv, 0);
    rec(64, 40, 1, 0);
    rec(64, 64, 0, 0);
    rec(64, 100, 0, 1);
    snap();
    chk("mix_valid", a_sv, 1);
    chk("mix_frame", a_fc, 3);
    chk("mix_pad", a_pc, 1);
    chk("mix_trunc", a_tc, 1);
    chk("mix_bytes", a_bc, 192);
    chk("mix_pad_bytes", a_pb, 24);
    chk("mix_trunc_bytes", a_tb, 36);
    chk("mix_min", a_mn, 64);
    chk("mix_max", a_mx, 64);
    chk("mix_nc_frame", n_fc, 3);
    tick();
    chk("mix_valid_once", a_sv, 0);
    clear = 1;
    tick();
    clear = 0;
    valid = 1; len = 80; orig = 80; snapshot = 1;
    tick();
    valid = 0; snapshot = 0;
    chk("cosnap_frame", a_fc, 1);
    chk("cosnap_bytes", a_bc, 80);
    chk("cosnap_nc_frame", n_fc, 1);
    snap();
    chk("after_cosnap_frame", a_fc, 0);
    chk("after_cosnap_min", a_mn, 0);
    chk("after_cosnap_nc_frame", n_fc, 1);
    chk("after_cosnap_nc_bytes", n_bc, 80);
    snap();
    chk("consec_valid", a_sv, 1);
    chk("consec_nc_frame", n_fc, 1);
    rec(200, 200, 0, 0);
    valid = 1; len = 60; orig = 60; clear = 1;
    tick();
    valid = 0; clear = 0;
    chk("clear_no_valid", a_sv, 0);
    chk("clear_holds_stat", a_fc, 0);
    snap();
    chk("clear_frame", a_fc, 1);
    chk("clear_bytes", a_bc, 60);
    chk("clear_min", a_mn, 60);
    chk("clear_max", a_mx, 60);
    clear = 1;
    tick();
    clear = 0;
    valid = 1; len = 10; orig = 10;
    repeat (20) tick();
    valid = 0;
    snap();
    chk("sat_w4_frame", w_fc, 15);
    chk("sat_w4_bytes", w_bc, 200);
    chk("sat_w32_frame", a_fc, 20);
    valid = 1; len = 5; orig = 5; snapshot = 1; clear = 1;
    tick();
    valid = 0; snapshot = 0; clear = 0;
    chk("snapclr_nc_frame", n_fc, 21);
    chk("snapclr_nc_bytes", n_bc, 205);
    chk("snapclr_nc_min", n_mn, 5);
    chk("snapclr_nc_max", n_mx, 10);
    snap();
    chk("snapclr_nc_next_frame", n_fc, 0);
    chk("snapclr_nc_next_bytes", n_bc, 0);
    rec(100, 100, 0, 0);
    snap();
    chk("pre_rst_frame", a_fc, 1);
    valid = 1; len = 77; orig = 77; rst = 1;
    tick();
    valid = 0; rst = 0;
    chk("midrst_ready", a_rdy, 0);
    chk("midrst_frame", a_fc, 0);
    chk("midrst_bytes", a_bc, 0);
    tick();
    chk("midrst_ready_back", a_rdy, 1);
    rec(1500, 1500, 0, 0);
    snap();
    chk("post_rst_frame", a_fc, 1);
    chk("post_rst_min", a_mn, 1500);
    chk("post_rst_max", a_mx, 1500);
    chk("post_rst_bytes", a_bc, 1500);
    rec(300, 300, 0, 0);
    rec(20, 20, 0, 0);
    rec(700, 700, 0, 0);
    snap();
    chk("minmax_min", a_mn, 20);
    chk("minmax_max", a_mx, 700);
    chk("minmax_bytes", a_bc, 1020);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
